debug_relay: RTL
================

Name: debug_relay

Overview:
- Merges the per-node ASCII debug streams (char + strobe, no backpressure) of N_CH sources into one stream feeding ring_buffer/uart.
- Sits between the controller and node debuggers on one side and the ring buffer on the other. It replaces the single hard-wired controller-to-ring_buffer link.
- Line-granular round-robin arbitration keeps lines from different sources from interleaving. An optional "<id>:" prefix is added at the start of each line.

Parameters:
- N_CH, 2, number of debug sources (1..16).
- DATA_WIDTH, 7, ASCII character width (`ASCII_WIDTH).
- FIFO_DEPTH, 16, per-channel FIFO entries (power of 2, >=2).
- PREFIX_EN, 1, 1 = emit hex channel id and ':' before each line.
- NEWLINE, 7'h0A, character that terminates a line.
- LINE_TIMEOUT, 255, idle cycles mid-line before the line is force-closed (>=1).

Ports:
- clk  in  1  system clock
- res_n  in  1  asynchronous active-low reset
- ascii_c  in  N_CH*DATA_WIDTH  per-channel char; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- ascii_s  in  N_CH  per-channel one-cycle strobe; ascii_c is valid when high
- out_data  out  DATA_WIDTH  merged char
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts (top wires !ring_buffer.full)
- overflow  out  N_CH  sticky per-channel drop flag
- active_ch  out  4  currently granted channel (0 when idle)

Behaviour:
- Reset: all outputs 0, FIFOs empty, state IDLE, round-robin pointer 0, timeout counter 0.
  - res_n is asynchronous. Asserting it mid-line discards all buffered chars and any partial output without emitting a newline.
- Per-channel FIFO write:
  - A char is written on ascii_s[i]=1.
  - If the FIFO count equals FIFO_DEPTH at the start of the cycle, the char is dropped and overflow[i] is set. This holds even if a pop occurs in the same cycle.
  - overflow clears only on reset.
- Output handshake:
  - A transfer occurs on each cycle with out_valid && out_ready.
  - out_data/out_valid are registered and held stable while out_valid && !out_ready.
  - A new char loads only when the output register is empty or transferring that cycle, which gives 1 char/cycle throughput.
- FSM states and transitions:
  - IDLE: search from pointer rr upward (wrapping) for the first non-empty FIFO. On a hit, grant it: active_ch = granted channel, rr = granted+1 mod N_CH. Next state is PFX_ID if PREFIX_EN, else STREAM, and the first char is loaded in the same cycle.
  - PFX_ID: load the hex digit of the id ('0'-'9','A'-'F') -> PFX_SEP.
  - PFX_SEP: load ':' -> STREAM.
  - STREAM: pop a char from the granted FIFO when the output register is free.
    - If the popped char is NEWLINE, go to IDLE after loading it.
    - If the FIFO is empty, increment the timeout counter. The counter resets on every pop.
    - When the counter reaches LINE_TIMEOUT, go to CLOSE.
  - CLOSE: load NEWLINE -> IDLE.
- Grant release rules:
  - A grant is never released mid-line except via CLOSE.
  - Strobes on other channels during a line only fill their FIFOs.
- Latency (PREFIX_EN=0, idle channel, out_ready=1): strobe at cycle t -> FIFO write at t, grant at t+1, out_valid at t+2.
  - With PREFIX_EN=1: id at t+2, ':' at t+3, char at t+4.
- A NEWLINE arriving as the first char of a line is still prefixed (yields "<id>:\n").
- Simultaneous strobes on several channels in IDLE are served in round-robin order, one full line each.
- A strobe on the granted channel in the same cycle its FIFO goes empty is written normally. It is popped in a later cycle and resets the timeout counter.

Test Plan:
1. PREFIX_EN=1, N_CH=2: ch1 strobes 'H','i',0x0A on consecutive cycles, out_ready=1.
   -> out stream '1',':','H','i',0x0A; first out_valid 2 cycles after the 'H' strobe; active_ch=1 during the line, then IDLE.
2. Both channels strobe "A\n" (ch0) and "B\n" (ch1) in the same cycles with rr=0.
   -> "0:A\n1:B\n" with no interleaving; repeat the scenario -> ch0 first again, since rr wrapped to 0.
3. ch0 sends 'X' only, LINE_TIMEOUT=4.
   -> '0',':','X', then 4 idle cycles, then 0x0A forced; meanwhile ch1 "Y\n" queued -> "1:Y\n" follows.
4. FIFO_DEPTH=4, out_ready=0, ch0 strobes 6 chars.
   -> 4 stored, overflow[0]=1 after the 5th; release out_ready -> only the first 4 chars appear, and overflow stays 1.
5. Backpressure: toggle out_ready 1,0,0,1 mid-line.
   -> out_data is held constant while stalled; no char is lost or duplicated; the output equals the input sequence.
6. Assert res_n low while out_valid=1 mid-line.
   -> out_valid=0, overflow=0, active_ch=0 immediately; after release, a new "Z\n" on ch0 -> "0:Z\n", with no residue.

Source files
------------

// File: rtl/debug_relay.sv
// debug_relay: merges per-channel ASCII debug streams into one output stream.
// Arbitration is per line and round robin, so lines from different sources never
// interleave. Each line can optionally start with a "<hex id>:" prefix. A line that
// stalls mid-way is closed with a forced NEWLINE after LINE_TIMEOUT idle cycles.
module debug_relay #(
  parameter int unsigned            N_CH         = 2,
  parameter int unsigned            DATA_WIDTH   = 7,
  parameter int unsigned            FIFO_DEPTH   = 16,
  parameter bit                     PREFIX_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0]  NEWLINE      = DATA_WIDTH'(8'h0A),
  parameter int unsigned            LINE_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       res_n,
  input  logic [N_CH*DATA_WIDTH-1:0] ascii_c,
  input  logic [N_CH-1:0]            ascii_s,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_CH-1:0]            overflow,
  output logic [3:0]                 active_ch
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TOW  = $clog2(LINE_TIMEOUT + 1);

  localparam logic [DATA_WIDTH-1:0] SEP_CHAR = DATA_WIDTH'(8'h3A);

  typedef enum logic [2:0] {
    StIdle,
    StPfxId,
    StPfxSep,
    StStream,
    StClose
  } state_e;

  // Per-channel FIFO state
  logic [DATA_WIDTH-1:0] mem_q    [N_CH][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q [N_CH];
  logic [AW-1:0]         rd_ptr_q [N_CH];
  logic [CNTW-1:0]       count_q  [N_CH];
  logic [N_CH-1:0]       overflow_q;
  logic [N_CH-1:0]       push;
  logic [N_CH-1:0]       pop;
  logic [N_CH-1:0]       empty;

  // Arbiter / output state
  state_e                state_q, state_d;
  logic [CW-1:0]         gnt_q, gnt_d;
  logic [CW-1:0]         rr_q, rr_d;
  logic [TOW-1:0]        to_q, to_d;
  logic [3:0]            active_q, active_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  found;
  logic [CW-1:0]         sel;
  logic [CW-1:0]         sel_next;
  logic [DATA_WIDTH-1:0] head_sel;
  logic [DATA_WIDTH-1:0] head_gnt;
  logic                  out_free;
  logic                  pop_en;
  logic [CW-1:0]         pop_ch;

  function automatic logic [DATA_WIDTH-1:0] hex_digit(input logic [3:0] v);
    if (v < 4'd10) begin
      return DATA_WIDTH'(8'h30 + {4'd0, v});
    end
    return DATA_WIDTH'(8'h37 + {4'd0, v});
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign empty[i] = (count_q[i] == '0);
    // A full FIFO drops the char even if it is popped this cycle.
    assign push[i]  = ascii_s[i] && (count_q[i] != CNTW'(FIFO_DEPTH));
  end

  assign head_sel = mem_q[sel][rd_ptr_q[sel]];
  assign head_gnt = mem_q[gnt_q][rd_ptr_q[gnt_q]];
  assign sel_next = (sel == CW'(N_CH - 1)) ? '0 : sel + 1'b1;

  // FIFO storage, no reset needed since pointers/counts gate every read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= ascii_c[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow flags.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (push[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        end
        if (push[i] && !pop[i]) begin
          count_q[i] <= count_q[i] + 1'b1;
        end else if (!push[i] && pop[i]) begin
          count_q[i] <= count_q[i] - 1'b1;
        end
        if (ascii_s[i] && !push[i]) begin
          overflow_q[i] <= 1'b1;
        end
      end
    end
  end

  // Round-robin search: first non-empty FIFO at or after rr_q, wrapping.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      if (!found && !empty[CW'(idx)]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
  end

  // Next-state logic: grant, prefix, streaming, timeout and output register loads.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    to_d        = to_q;
    active_d    = active_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pop_en      = 1'b0;
    pop_ch      = gnt_q;
    pop         = '0;
    // Output register can take a new char when empty or draining this cycle.
    out_free    = !out_valid_q || out_ready;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d    = sel;
          rr_d     = sel_next;
          active_d = 4'(sel);
          to_d     = '0;
          if (PREFIX_EN) begin
            if (out_free) begin
              out_valid_d = 1'b1;
              out_data_d  = hex_digit(4'(sel));
              state_d     = StPfxSep;
            end else begin
              state_d = StPfxId;
            end
          end else if (out_free) begin
            pop_en      = 1'b1;
            pop_ch      = sel;
            out_valid_d = 1'b1;
            out_data_d  = head_sel;
            if (head_sel == NEWLINE) begin
              state_d  = StIdle;
              active_d = '0;
            end else begin
              state_d = StStream;
            end
          end else begin
            state_d = StStream;
          end
        end
      end

      StPfxId: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = hex_digit(4'(gnt_q));
          state_d     = StPfxSep;
        end
      end

      StPfxSep: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = SEP_CHAR;
          state_d     = StStream;
        end
      end

      StStream: begin
        if (empty[gnt_q]) begin
          // Source went quiet mid-line; close it once the budget is used up.
          if (to_q == TOW'(LINE_TIMEOUT - 1)) begin
            to_d    = TOW'(LINE_TIMEOUT);
            state_d = StClose;
          end else begin
            to_d = to_q + 1'b1;
          end
        end else if (out_free) begin
          pop_en      = 1'b1;
          pop_ch      = gnt_q;
          out_valid_d = 1'b1;
          out_data_d  = head_gnt;
          to_d        = '0;
          if (head_gnt == NEWLINE) begin
            state_d  = StIdle;
            active_d = '0;
          end
        end
      end

      StClose: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = NEWLINE;
          to_d        = '0;
          active_d    = '0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d  = StIdle;
        active_d = '0;
      end
    endcase

    if (pop_en) begin
      pop[pop_ch] = 1'b1;
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      rr_q        <= '0;
      to_q        <= '0;
      active_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      to_q        <= to_d;
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign active_ch = active_q;

endmodule
